// File: rtl/ltc2308_emulator.sv
// LTC2308 stand-in: answers a controller's CONVST/SCK/SDI with 12-bit codes
// derived from eight parallel channel values, all in the clk_clk domain.
module ltc2308_emulator #(
  parameter int          CONV_CYCLES = 80,
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  CFG_DEFAULT = 6'b100010
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        convst,
  input  logic        sck,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [95:0] ch_data,
  output logic        busy,
  output logic [5:0]  cfg_word,
  output logic [15:0] conv_count,
  output logic [1:0]  state_dbg
);

  // Handshake: none. Master lines are free-running asynchronous inputs; a
  // conversion starts on a synchronized CONVST rise outside CONV, and sdo is
  // meaningful only while sdo_oe is high.

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DATA = 2'd2} state_t;

  localparam int CW = $clog2(CONV_CYCLES + 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] convst_ff, sck_ff, sdi_ff;
  logic                   convst_d, sck_d;
  logic                   convst_s, sck_s, sdi_s;
  logic                   convst_rise, sck_rise, sck_fall;
  logic [CW-1:0]          cnt;
  logic [11:0]            out_sr;
  logic [5:0]             in_sr;
  logic [2:0]             cfg_bits;
  logic [11:0]            snap [8];

  logic [2:0]         pos_idx, neg_idx;
  logic [11:0]        v_pos, v_neg, result;
  logic signed [12:0] diff, half;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      convst_ff <= '0;
      sck_ff    <= '0;
      sdi_ff    <= '0;
      convst_d  <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      convst_ff <= {convst_ff[SYNC_STAGES-2:0], convst};
      sck_ff    <= {sck_ff[SYNC_STAGES-2:0], sck};
      sdi_ff    <= {sdi_ff[SYNC_STAGES-2:0], sdi};
      convst_d  <= convst_s;
      sck_d     <= sck_s;
    end
  end

  assign convst_s    = convst_ff[SYNC_STAGES-1];
  assign sck_s       = sck_ff[SYNC_STAGES-1];
  assign sdi_s       = sdi_ff[SYNC_STAGES-1];
  assign convst_rise = convst_s & ~convst_d;
  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;

  // cfg_word = {S/D, O/S, S1, S0, UNI, SLP}; {S1,S0,O/S} is both the
  // single-ended channel and the positive input of the differential pair.
  always_comb begin
    pos_idx = {cfg_word[3], cfg_word[2], cfg_word[4]};
    neg_idx = {cfg_word[3], cfg_word[2], ~cfg_word[4]};
    v_pos   = snap[pos_idx];
    v_neg   = snap[neg_idx];
    diff    = $signed({1'b0, v_pos}) - $signed({1'b0, v_neg});
    half    = diff >>> 1;
    result  = '0;
    if (cfg_word[5]) begin
      result = cfg_word[1] ? v_pos : (v_pos ^ 12'h800);
    end else if (cfg_word[1]) begin
      result = diff[12] ? 12'h000 : diff[11:0];
    end else begin
      // |diff| <= 4095, so the halved value always fits in 12 bits signed.
      result = half[11:0];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sdo_oe     <= 1'b0;
      cfg_word   <= CFG_DEFAULT;
      conv_count <= '0;
      cnt        <= '0;
      out_sr     <= '0;
      in_sr      <= '0;
      cfg_bits   <= '0;
      for (int i = 0; i < 8; i++) snap[i] <= '0;
    end else if (convst_rise && state != CONV) begin
      state    <= CONV;
      busy     <= 1'b1;
      sdo_oe   <= 1'b0;
      cnt      <= '0;
      out_sr   <= '0;
      cfg_bits <= '0;
      if (cfg_bits == 3'd6) cfg_word <= in_sr;
      for (int i = 0; i < 8; i++) snap[i] <= ch_data[12*i +: 12];
    end else begin
      case (state)
        CONV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(CONV_CYCLES - 1)) begin
            out_sr     <= result;
            conv_count <= conv_count + 1'b1;
            busy       <= 1'b0;
            sdo_oe     <= ~convst_s;
            state      <= DATA;
          end
        end
        DATA: begin
          sdo_oe <= ~convst_s;
          if (sck_fall) out_sr <= {out_sr[10:0], 1'b0};
          // Only the first six SDI bits after a conversion form the next config.
          if (sck_rise && cfg_bits != 3'd6) begin
            in_sr    <= {in_sr[4:0], sdi_s};
            cfg_bits <= cfg_bits + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sdo       = out_sr[11];
  assign state_dbg = state;

endmodule
